// File: rtl/iob_dbus_split.sv
// IOb data-bus splitter: routes each CPU data request to a slave port chosen by address MSBs,
// steers the single outstanding read response back, and answers unmapped or hung accesses locally.
module iob_dbus_split #(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter int                N_SLAVES = 3,
    parameter int                SEL_W    = 2,
    parameter int                TIMEOUT  = 1024,
    parameter logic [DATA_W-1:0] ERR_DATA = DATA_W'(32'hDEADBEEF),
    localparam int               WSTRB_W  = DATA_W / 8,
    localparam int               REQ_W    = 1 + ADDR_W + DATA_W + WSTRB_W,
    localparam int               RESP_W   = DATA_W + 2
) (
    input  logic                       clk_i,
    input  logic                       arst_i,
    input  logic                       cke_i,
    input  logic [REQ_W-1:0]           m_req_i,
    output logic [RESP_W-1:0]          m_resp_o,
    output logic [N_SLAVES*REQ_W-1:0]  s_req_o,
    input  logic [N_SLAVES*RESP_W-1:0] s_resp_i,
    output logic                       err_o,
    output logic [ADDR_W-1:0]          err_addr_o,
    input  logic                       err_clr_i
);

    localparam int               N_IDX    = 2 ** SEL_W;
    localparam int               TMO_W    = $clog2(TIMEOUT);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
    localparam logic [SEL_W:0]   N_MAP    = (SEL_W + 1)'(N_SLAVES);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_RD,
        ST_ERR,
        ST_TMO
    } state_e;

    state_e             state_q, state_d;
    logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;
    logic [SEL_W-1:0]   pend_sel_q, pend_sel_d;
    logic [ADDR_W-1:0]  pend_addr_q, pend_addr_d;
    logic               err_rd_q, err_rd_d;
    logic               err_q, err_d;
    logic [ADDR_W-1:0]  err_addr_q, err_addr_d;

    logic               m_avalid;
    logic [ADDR_W-1:0]  m_addr;
    logic [DATA_W-1:0]  m_wdata;
    logic [WSTRB_W-1:0] m_wstrb;
    logic [SEL_W-1:0]   sel;
    logic               mapped;
    logic               pend_rvalid;
    logic               accept_en;
    logic               m_ready;
    logic               acc;
    logic               acc_rd;
    logic               rvalid_mux;
    logic [DATA_W-1:0]  rdata_mux;
    logic               set_err;
    logic [ADDR_W-1:0]  set_addr;

    logic               s_ready  [N_IDX];
    logic               s_rvalid [N_IDX];
    logic [DATA_W-1:0]  s_rdata  [N_IDX];

    assign m_avalid = m_req_i[REQ_W-1];
    assign m_addr   = m_req_i[REQ_W-2 -: ADDR_W];
    assign m_wdata  = m_req_i[WSTRB_W +: DATA_W];
    assign m_wstrb  = m_req_i[WSTRB_W-1:0];
    assign sel      = m_addr[ADDR_W-1 -: SEL_W];
    assign mapped   = ({1'b0, sel} < N_MAP);

    // Unpopulated select codes read back as an idle slave so every index is safe.
    for (genvar gi = 0; gi < N_IDX; gi++) begin : g_resp
        if (gi < N_SLAVES) begin : g_map
            assign s_ready[gi]  = s_resp_i[gi*RESP_W];
            assign s_rvalid[gi] = s_resp_i[gi*RESP_W + 1];
            assign s_rdata[gi]  = s_resp_i[gi*RESP_W + 2 +: DATA_W];
        end else begin : g_unmap
            assign s_ready[gi]  = 1'b0;
            assign s_rvalid[gi] = 1'b0;
            assign s_rdata[gi]  = '0;
        end
    end

    assign pend_rvalid = s_rvalid[pend_sel_q];
    assign accept_en   = (state_q == ST_IDLE) || ((state_q == ST_WAIT_RD) && pend_rvalid);
    assign m_ready     = accept_en & (mapped ? s_ready[sel] : 1'b1);
    assign acc         = m_avalid & m_ready;
    assign acc_rd      = acc & ~(|m_wstrb);

    for (genvar gi = 0; gi < N_SLAVES; gi++) begin : g_req
        assign s_req_o[gi*REQ_W +: REQ_W] = {
            m_avalid & accept_en & (sel == SEL_W'(gi)) & ~arst_i,
            m_addr, m_wdata, m_wstrb
        };
    end

    always_comb begin
        rvalid_mux = 1'b0;
        rdata_mux  = '0;
        case (state_q)
            ST_WAIT_RD: begin
                rvalid_mux = pend_rvalid;
                rdata_mux  = s_rdata[pend_sel_q];
            end
            ST_ERR: begin
                rvalid_mux = err_rd_q;
                rdata_mux  = err_rd_q ? ERR_DATA : '0;
            end
            ST_TMO: begin
                rvalid_mux = 1'b1;
                rdata_mux  = ERR_DATA;
            end
            default: ;
        endcase
    end

    assign m_resp_o   = arst_i ? '0 : {rdata_mux, rvalid_mux, m_ready};
    assign err_o      = err_q;
    assign err_addr_o = err_addr_q;

    always_comb begin
        state_d     = state_q;
        tmo_cnt_d   = tmo_cnt_q;
        pend_sel_d  = pend_sel_q;
        pend_addr_d = pend_addr_q;
        err_rd_d    = err_rd_q;
        err_d       = err_q;
        err_addr_d  = err_addr_q;
        set_err     = 1'b0;
        set_addr    = '0;
        case (state_q)
            ST_IDLE, ST_WAIT_RD: begin
                if (accept_en) begin
                    if (acc && !mapped) begin
                        state_d  = ST_ERR;
                        err_rd_d = acc_rd;
                        set_err  = 1'b1;
                        set_addr = m_addr;
                    end else if (acc_rd) begin
                        state_d     = ST_WAIT_RD;
                        pend_sel_d  = sel;
                        pend_addr_d = m_addr;
                        tmo_cnt_d   = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    // Compare the incremented count so the TMO cycle lands TIMEOUT cycles after accept.
                    tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                    if (tmo_cnt_d == TMO_LAST) begin
                        state_d = ST_TMO;
                    end
                end
            end
            ST_ERR: state_d = ST_IDLE;
            ST_TMO: begin
                state_d  = ST_IDLE;
                set_err  = 1'b1;
                set_addr = pend_addr_q;
            end
            default: state_d = ST_IDLE;
        endcase

        if (err_clr_i) begin
            err_d      = 1'b0;
            err_addr_d = '0;
        end else if (set_err) begin
            err_d = 1'b1;
            if (!err_q) begin
                err_addr_d = set_addr;
            end
        end
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q     <= ST_IDLE;
            tmo_cnt_q   <= '0;
            pend_sel_q  <= '0;
            pend_addr_q <= '0;
            err_rd_q    <= 1'b0;
            err_q       <= 1'b0;
            err_addr_q  <= '0;
        end else if (cke_i) begin
            state_q     <= state_d;
            tmo_cnt_q   <= tmo_cnt_d;
            pend_sel_q  <= pend_sel_d;
            pend_addr_q <= pend_addr_d;
            err_rd_q    <= err_rd_d;
            err_q       <= err_d;
            err_addr_q  <= err_addr_d;
        end
    end

endmodule

// File: tb/tb_iob_dbus_split.sv
// Bench for iob_dbus_split: directed scenarios followed by random transactions, each checked
// against expected timing/data derived from address map, read latency and timeout rules.
module tb_iob_dbus_split;

    localparam int ADDR_W   = 32;
    localparam int DATA_W   = 32;
    localparam int N_SLAVES = 3;
    localparam int SEL_W    = 2;
    localparam int TIMEOUT  = 8;
    localparam int WSTRB_W  = DATA_W / 8;
    localparam int REQ_W    = 1 + ADDR_W + DATA_W + WSTRB_W;
    localparam int RESP_W   = DATA_W + 2;
    localparam logic [31:0] ERR_DATA = 32'hDEADBEEF;

    logic                       clk_i = 1'b0;
    logic                       arst_i;
    logic                       cke_i;
    logic                       err_clr_i;
    logic [REQ_W-1:0]           m_req_i;
    logic [RESP_W-1:0]          m_resp_o;
    logic [N_SLAVES*REQ_W-1:0]  s_req_o;
    logic [N_SLAVES*RESP_W-1:0] s_resp_i;
    logic                       err_o;
    logic [ADDR_W-1:0]          err_addr_o;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic        exp_err;
    logic [31:0] exp_err_addr;

    always #5 clk_i = ~clk_i;

    iob_dbus_split #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .N_SLAVES(N_SLAVES),
        .SEL_W   (SEL_W),
        .TIMEOUT (TIMEOUT),
        .ERR_DATA(ERR_DATA)
    ) dut (
        .clk_i     (clk_i),
        .arst_i    (arst_i),
        .cke_i     (cke_i),
        .m_req_i   (m_req_i),
        .m_resp_o  (m_resp_o),
        .s_req_o   (s_req_o),
        .s_resp_i  (s_resp_i),
        .err_o     (err_o),
        .err_addr_o(err_addr_o),
        .err_clr_i (err_clr_i)
    );

    wire              m_ready  = m_resp_o[0];
    wire              m_rvalid = m_resp_o[1];
    wire [DATA_W-1:0] m_rdata  = m_resp_o[RESP_W-1:2];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [N_SLAVES-1:0] get_av();
        logic [N_SLAVES-1:0] v;
        for (int k = 0; k < N_SLAVES; k++) v[k] = s_req_o[k*REQ_W + REQ_W - 1];
        return v;
    endfunction

    task automatic set_req(input logic av, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        m_req_i = {av, a, d, s};
    endtask

    task automatic set_slave(input int k, input logic [31:0] rd, input logic rv, input logic rdy);
        s_resp_i[k*RESP_W +: RESP_W] = {rd, rv, rdy};
    endtask

    // Random responses on every slave except the one under test; those must never reach the master.
    task automatic noise(input int target);
        for (int k = 0; k < N_SLAVES; k++)
            if (k != target) set_slave(k, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    endtask

    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            set_req(1'b0, $urandom, $urandom, 4'($urandom));
            noise(-1);
            @(negedge clk_i);
            check("idle_rvalid", m_rvalid, 1'b0);
            check("idle_avalid", get_av(), '0);
            next_cycle();
        end
    endtask

    task automatic clr_err();
        set_req(1'b0, 32'h0, 32'h0, 4'h0);
        noise(-1);
        err_clr_i = 1'b1;
        next_cycle();
        err_clr_i    = 1'b0;
        exp_err      = 1'b0;
        exp_err_addr = '0;
        check("err_clr", err_o, 1'b0);
        check("err_addr_clr", err_addr_o, 32'h0);
    endtask

    // One complete transaction starting from IDLE. lat = cycles after accept at which the slave pulses rvalid.
    task automatic do_txn(input logic [31:0] addr, input bit is_wr, input int rdy_dly,
                          input int lat, input logic [31:0] rdat);
        int                  sel;
        bit                  mapped;
        bit                  exp_rdy;
        bit                  exp_v;
        int                  n_end;
        logic [3:0]          wstrb;
        logic [31:0]         wdata;
        logic [N_SLAVES-1:0] one_hot;
        sel    = int'(addr[31:30]);
        mapped = (sel < N_SLAVES);
        wstrb  = is_wr ? 4'($urandom_range(1, 15)) : 4'h0;
        wdata  = $urandom;
        one_hot = '0;
        if (mapped) one_hot[sel] = 1'b1;

        for (int c = 0; c < 8; c++) begin
            set_req(1'b1, addr, wdata, wstrb);
            noise(sel);
            if (mapped) set_slave(sel, $urandom, 1'b0, c >= rdy_dly);
            @(negedge clk_i);
            exp_rdy = !mapped || (c >= rdy_dly);
            check("req_ready", m_ready, exp_rdy);
            check("req_avalid", get_av(), one_hot);
            check("req_rvalid", m_rvalid, 1'b0);
            check("req_payload", s_req_o[(mapped ? sel : 0)*REQ_W +: REQ_W-1], {addr, wdata, wstrb});
            next_cycle();
            if (exp_rdy) break;
        end

        if (!mapped) begin
            if (!exp_err) exp_err_addr = addr;
            exp_err = 1'b1;
            // A fresh request during the error cycle must not be accepted.
            set_req(1'b1, {2'b00, 30'($urandom)}, $urandom, 4'h0);
            noise(0);
            set_slave(0, $urandom, 1'b0, 1'b1);
            @(negedge clk_i);
            check("err_rvalid", m_rvalid, !is_wr);
            if (!is_wr) check("err_rdata", m_rdata, ERR_DATA);
            check("err_ready", m_ready, 1'b0);
            check("err_avalid", get_av(), '0);
            check("err_flag", err_o, exp_err);
            check("err_addr", err_addr_o, exp_err_addr);
            next_cycle();
            return;
        end
        if (is_wr) return;

        n_end = (lat <= TIMEOUT - 1) ? lat : ((lat > TIMEOUT) ? lat : TIMEOUT);
        for (int c = 1; c <= n_end; c++) begin
            set_req(1'b0, $urandom, $urandom, 4'($urandom));
            noise(sel);
            set_slave(sel, rdat, c == lat, 1'($urandom_range(0, 1)));
            @(negedge clk_i);
            exp_v = (lat <= TIMEOUT - 1) ? (c == lat) : (c == TIMEOUT);
            check("rd_rvalid", m_rvalid, exp_v);
            if (exp_v) check("rd_rdata", m_rdata, (lat <= TIMEOUT - 1) ? rdat : ERR_DATA);
            check("rd_avalid", get_av(), '0);
            next_cycle();
            if (c == TIMEOUT && lat >= TIMEOUT) begin
                if (!exp_err) exp_err_addr = addr;
                exp_err = 1'b1;
            end
        end
        check("rd_err_flag", err_o, exp_err);
        check("rd_err_addr", err_addr_o, exp_err_addr);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a0, a2, d0, d2, r_addr;
        int          s, rdy, lat;
        bit          w;

        // Reset: outputs quiet even with a live request and responsive slaves.
        arst_i = 1'b1; cke_i = 1'b1; err_clr_i = 1'b0;
        exp_err = 1'b0; exp_err_addr = '0;
        set_req(1'b1, 32'h0000_0040, 32'h1, 4'h0);
        noise(-1);
        set_slave(0, 32'hA5A5_A5A5, 1'b1, 1'b1);
        next_cycle();
        next_cycle();
        check("rst_resp", m_resp_o, '0);
        check("rst_avalid", get_av(), '0);
        check("rst_err", err_o, 1'b0);
        check("rst_err_addr", err_addr_o, 32'h0);
        set_req(1'b0, 32'h0, 32'h0, 4'h0);
        arst_i = 1'b0;
        idle(1);

        do_txn(32'h4000_0010, 1'b0, 0, 2, 32'h1234_5678);
        do_txn(32'h0000_0100, 1'b1, 0, 0, 32'h0);
        do_txn(32'h8000_0020, 1'b0, 0, 3, 32'hCAFE_0002);
        idle(1);

        // Back-to-back reads: slave 2 must wait for slave 0's rvalid, then go in the same cycle.
        a0 = {2'b00, 30'($urandom)}; a2 = {2'b10, 30'($urandom)};
        d0 = $urandom; d2 = $urandom;
        set_req(1'b1, a0, 32'h0, 4'h0);
        for (int k = 0; k < N_SLAVES; k++) set_slave(k, 32'h0, 1'b0, 1'b1);
        @(negedge clk_i);
        check("b2b_acc0_ready", m_ready, 1'b1);
        check("b2b_acc0_avalid", get_av(), 3'b001);
        next_cycle();
        for (int c = 1; c <= 2; c++) begin
            set_req(1'b1, a2, 32'h0, 4'h0);
            @(negedge clk_i);
            check("b2b_hold_ready", m_ready, 1'b0);
            check("b2b_hold_avalid", get_av(), 3'b000);
            check("b2b_hold_rvalid", m_rvalid, 1'b0);
            next_cycle();
        end
        set_slave(0, d0, 1'b1, 1'b1);
        @(negedge clk_i);
        check("b2b_rv0", m_rvalid, 1'b1);
        check("b2b_rd0", m_rdata, d0);
        check("b2b_acc2_ready", m_ready, 1'b1);
        check("b2b_acc2_avalid", get_av(), 3'b100);
        next_cycle();
        set_req(1'b0, 32'h0, 32'h0, 4'h0);
        set_slave(0, 32'h0, 1'b0, 1'b1);
        set_slave(2, d2, 1'b1, 1'b1);
        @(negedge clk_i);
        check("b2b_rv2", m_rvalid, 1'b1);
        check("b2b_rd2", m_rdata, d2);
        next_cycle();
        idle(1);

        // Unmapped accesses: first address sticks until cleared.
        do_txn(32'hC000_0000, 1'b0, 0, 1, 32'h0);
        do_txn(32'hC000_1234, 1'b1, 0, 1, 32'h0);
        clr_err();

        // Hung slave with a late rvalid after the timeout response.
        do_txn(32'h4000_0040, 1'b0, 0, TIMEOUT + 1, 32'h7777_0001);
        idle(1);

        // Asynchronous reset while a read is pending.
        set_req(1'b1, 32'h4000_0080, 32'h0, 4'h0);
        noise(1);
        set_slave(1, 32'h0, 1'b0, 1'b1);
        @(negedge clk_i);
        check("arst_acc_ready", m_ready, 1'b1);
        next_cycle();
        set_req(1'b0, 32'h0, 32'h0, 4'h0);
        set_slave(1, 32'h5555_AAAA, 1'b0, 1'b0);
        next_cycle();
        set_slave(1, 32'h5555_AAAA, 1'b1, 1'b1);
        set_req(1'b1, {2'b00, 30'h10}, 32'h0, 4'h0);
        set_slave(0, 32'h0, 1'b0, 1'b1);
        #1;
        check("pre_arst_rvalid", m_rvalid, 1'b1);
        check("pre_arst_avalid", get_av(), 3'b001);
        arst_i = 1'b1;
        #1;
        exp_err = 1'b0; exp_err_addr = '0;
        check("arst_resp", m_resp_o, '0);
        check("arst_avalid", get_av(), '0);
        check("arst_err", err_o, 1'b0);
        check("arst_err_addr", err_addr_o, 32'h0);
        next_cycle();
        set_req(1'b0, 32'h0, 32'h0, 4'h0);
        arst_i = 1'b0;
        idle(1);
        do_txn(32'h4000_00C0, 1'b0, 1, 2, 32'hBEEF_0003);

        // Clock enable held low for 5 cycles while waiting stretches the timeout by 5.
        r_addr = 32'h8000_0100;
        set_req(1'b1, r_addr, 32'h0, 4'h0);
        for (int k = 0; k < N_SLAVES; k++) set_slave(k, 32'h0, 1'b0, 1'b1);
        @(negedge clk_i);
        check("cke_acc_ready", m_ready, 1'b1);
        next_cycle();
        set_req(1'b0, 32'h0, 32'h0, 4'h0);
        for (int c = 1; c <= TIMEOUT + 5; c++) begin
            cke_i = !(c >= 2 && c <= 6);
            @(negedge clk_i);
            check("cke_rvalid", m_rvalid, c == TIMEOUT + 5);
            if (c == TIMEOUT + 5) check("cke_rdata", m_rdata, ERR_DATA);
            next_cycle();
        end
        cke_i = 1'b1;
        if (!exp_err) exp_err_addr = r_addr;
        exp_err = 1'b1;
        check("cke_err", err_o, exp_err);
        check("cke_err_addr", err_addr_o, exp_err_addr);

        for (int i = 0; i < 40; i++) begin
            s   = $urandom_range(0, 3);
            w   = ($urandom_range(0, 2) == 0);
            rdy = $urandom_range(0, 2);
            lat = ($urandom_range(0, 3) == 0) ? $urandom_range(TIMEOUT - 1, TIMEOUT + 2)
                                              : $urandom_range(1, 4);
            do_txn({2'(s), 30'($urandom)}, w, rdy, lat, $urandom);
            if ($urandom_range(0, 4) == 0) idle(1);
            if ($urandom_range(0, 7) == 0) clr_err();
        end
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
